// File: rtl/note_fetch.sv
// rtl/note_fetch.sv - fetch a note word on every beat address change and turn it into a gated tone half-period
module note_fetch #(
    parameter int          ADDR_W         = 10,
    parameter int          NOTE_W         = 7,
    parameter int          DIV_W          = 22,
    parameter logic [31:0] MAIN_CLK_SPEED = 32'd50000000,
    parameter int          GAP_CYCLES     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] beat_addr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [NOTE_W-1:0] mem_rdata,
    output logic [NOTE_W-1:0] note_num,
    output logic [DIV_W-1:0]  half_period,
    output logic              gate,
    output logic              note_valid
);

    localparam int OCT_W = 4;
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT,
        DIVIDE,
        GAP,
        PLAY
    } state_t;

    // Half-period of the lowest octave (MIDI 0..11) rounded to the nearest clk cycle.
    function automatic logic [DIV_W-1:0] base_calc(input int s);
        real f;
        real p;
        f = 440.0 * (2.0 ** ((real'(s) - 69.0) / 12.0));
        p = real'(MAIN_CLK_SPEED) / (2.0 * f);
        return DIV_W'($rtoi(p + 0.5));
    endfunction

    logic [DIV_W-1:0] base_tbl [12];

    for (genvar g = 0; g < 12; g++) begin : g_base
        localparam logic [DIV_W-1:0] BASE_V = base_calc(g);
        assign base_tbl[g] = BASE_V;
    end

    state_t            state;
    logic [ADDR_W-1:0] addr_q;
    logic              first;
    logic [NOTE_W-1:0] note;
    logic [NOTE_W-1:0] rem;
    logic [OCT_W-1:0]  oct;
    logic [GAP_W-1:0]  gap_cnt;

    logic              addr_diff;
    logic              start_fetch;
    logic              rem_small;
    logic              enter_play;
    logic [DIV_W-1:0]  play_period;

    assign addr_diff   = (beat_addr != addr_q);
    assign rem_small   = (rem < NOTE_W'(12));
    assign play_period = base_tbl[rem[3:0]] >> oct;

    // A new address wins over every other transition, including the play entry.
    always_comb begin
        start_fetch = 1'b0;
        enter_play  = 1'b0;
        case (state)
            IDLE, PLAY: start_fetch = addr_diff || first;
            READ, WAIT: start_fetch = addr_diff;
            DIVIDE: begin
                start_fetch = addr_diff;
                enter_play  = rem_small && (GAP_CYCLES == 0);
            end
            GAP: begin
                start_fetch = addr_diff;
                enter_play  = (gap_cnt == '0);
            end
            default: start_fetch = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            addr_q      <= '0;
            first       <= 1'b1;
            note        <= '0;
            rem         <= '0;
            oct         <= '0;
            gap_cnt     <= '0;
            mem_addr    <= '0;
            mem_rd_en   <= 1'b0;
            note_num    <= '0;
            half_period <= '0;
            gate        <= 1'b0;
            note_valid  <= 1'b0;
        end else begin
            mem_rd_en  <= 1'b0;
            note_valid <= 1'b0;
            if (start_fetch) begin
                state     <= READ;
                addr_q    <= beat_addr;
                first     <= 1'b0;
                mem_addr  <= beat_addr;
                mem_rd_en <= 1'b1;
                gate      <= 1'b0;
            end else if (enter_play) begin
                state      <= PLAY;
                note_num   <= note;
                note_valid <= 1'b1;
                if (note != '0) begin
                    half_period <= play_period;
                    gate        <= 1'b1;
                end
            end else begin
                case (state)
                    READ: state <= WAIT;
                    WAIT: begin
                        note  <= mem_rdata;
                        rem   <= mem_rdata;
                        oct   <= '0;
                        state <= DIVIDE;
                    end
                    DIVIDE: begin
                        if (!rem_small) begin
                            rem <= rem - NOTE_W'(12);
                            oct <= oct + OCT_W'(1);
                        end else begin
                            gap_cnt <= GAP_W'(GAP_CYCLES - 1);
                            state   <= GAP;
                        end
                    end
                    GAP: gap_cnt <= gap_cnt - GAP_W'(1);
                    default: state <= state;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_note_fetch.sv
// tb/tb_note_fetch.sv - scoreboard bench for note_fetch with directed and randomized beat sequences
module tb_note_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  beat_addr;
    logic [9:0]  mem_addr;
    logic        mem_rd_en;
    logic [6:0]  mem_rdata = '0;
    logic [6:0]  note_num;
    logic [21:0] half_period;
    logic        gate;
    logic        note_valid;

    note_fetch dut (
        .clk        (clk),
        .reset      (reset),
        .beat_addr  (beat_addr),
        .mem_addr   (mem_addr),
        .mem_rd_en  (mem_rd_en),
        .mem_rdata  (mem_rdata),
        .note_num   (note_num),
        .half_period(half_period),
        .gate       (gate),
        .note_valid (note_valid)
    );

    always #5 clk = ~clk;

    logic [6:0] mem [1024];
    always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [6:0]  note;
        logic [21:0] hp;
        logic        gate;
        int          cyc;
    } exp_t;

    exp_t        expq[$];
    int          checks   = 0;
    int          failures = 0;
    int          strobes  = 0;
    int          low_run  = 0;
    logic        gate_prev = 1'b0;
    logic [21:0] last_hp  = '0;

    task automatic check(input bit ok, input string name, input longint act, input longint req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at cycle %0d", name, act, req, cyc);
        end
    endtask

    function automatic int base_m(input int s);
        real f;
        f = 440.0 * (2.0 ** ((real'(s) - 69.0) / 12.0));
        return $rtoi(50000000.0 / (2.0 * f) + 0.5);
    endfunction

    // Expected note outputs and the negedge at which the note_valid pulse is seen.
    task automatic push_exp(input logic [9:0] a);
        exp_t e;
        int   n;
        int   o;
        n = int'(mem[a]);
        o = n / 12;
        if (n != 0) last_hp = 22'(base_m(n % 12) / (1 << o));
        e.note = mem[a];
        e.hp   = last_hp;
        e.gate = (n != 0);
        e.cyc  = cyc + 20 + o;
        expq.push_back(e);
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (gate && !gate_prev) check(low_run >= 16, "gate_gap", low_run, 16);
            low_run   = gate ? 0 : low_run + 1;
            gate_prev = gate;
            if (mem_rd_en) strobes++;
            if (note_valid) begin
                if (expq.size() == 0) begin
                    check(1'b0, "unexpected_note_valid", note_num, 0);
                end else begin
                    exp_t e;
                    e = expq.pop_front();
                    check(note_num == e.note, "note_num", note_num, e.note);
                    check(half_period == e.hp, "half_period", half_period, e.hp);
                    check(gate == e.gate, "gate", gate, e.gate);
                    check(cyc == e.cyc, "valid_cycle", cyc, e.cyc);
                end
            end
        end else begin
            low_run   = 0;
            gate_prev = 1'b0;
        end
    end

    task automatic wait_done();
        int n;
        n = 0;
        while (expq.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check(expq.size() == 0, "note_timeout", expq.size(), 0);
        expq.delete();
    endtask

    task automatic issue(input logic [9:0] a, input bit abort_first, input logic [9:0] mid, input int k);
        if (abort_first) begin
            @(negedge clk);
            beat_addr = mid;
            repeat (k) @(negedge clk);
        end else begin
            @(negedge clk);
        end
        beat_addr = a;
        push_exp(a);
        @(negedge clk);
        check(gate == 1'b0, "gate_low_after_change", gate, 0);
    endtask

    initial begin
        int s0;
        logic [9:0] a;
        logic [9:0] m;
        bit ab;
        for (int i = 0; i < 1024; i++)
            mem[i] = ($urandom_range(0, 9) == 0) ? 7'd0 : 7'($urandom_range(1, 127));
        mem[0] = 7'd69; mem[1] = 7'd60; mem[2] = 7'd0;
        mem[6] = 7'd69; mem[7] = 7'd69;
        mem[3] = 7'd100; mem[4] = 7'd50; mem[5] = 7'd60;
        reset     = 1'b1;
        beat_addr = '0;
        repeat (3) @(negedge clk);
        check(gate == 1'b0, "reset_gate", gate, 0);
        check(half_period == '0, "reset_half_period", half_period, 0);
        check(mem_rd_en == 1'b0 && note_valid == 1'b0 && note_num == '0, "reset_outputs",
              {mem_rd_en, note_valid, note_num}, 0);

        // Fetch of beat 0 after release: A4 in the lowest table entry shifted by five octaves
        s0    = strobes;
        reset = 1'b0;
        push_exp(10'd0);
        wait_done();
        check(strobes - s0 == 1, "first_strobes", strobes - s0, 1);
        check(mem_addr == 10'd0, "first_mem_addr", mem_addr, 0);
        check(half_period == 22'd56818, "a4_half_period", half_period, 56818);
        check(gate == 1'b1 && note_num == 7'd69, "a4_playing", {gate, note_num}, {1'b1, 7'd69});

        issue(10'd1, 1'b0, '0, 0);
        repeat (21) @(negedge clk);
        check(gate == 1'b0, "gate_low_e23", gate, 0);
        wait_done();
        check(half_period == 22'd95556, "c4_half_period", half_period, 95556);

        issue(10'd2, 1'b0, '0, 0);
        wait_done();
        check(gate == 1'b0 && half_period == 22'd95556, "rest_holds", {gate, half_period}, 95556);

        issue(10'd6, 1'b0, '0, 0);
        wait_done();
        issue(10'd7, 1'b0, '0, 0);
        wait_done();
        check(gate == 1'b1, "retrigger_gate", gate, 1);

        // Move off note 100 (eight octaves of division) while it is still being divided
        s0 = strobes;
        issue(10'd4, 1'b1, 10'd3, 5);
        wait_done();
        check(strobes - s0 == 2, "abort_strobes", strobes - s0, 2);

        issue(10'd5, 1'b0, '0, 0);
        repeat (11) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check(gate == 1'b0 && note_num == '0 && half_period == '0, "async_reset_outputs",
              {gate, note_num, half_period}, 0);
        check(mem_rd_en == 1'b0 && note_valid == 1'b0 && mem_addr == '0, "async_reset_strobe",
              {mem_rd_en, note_valid, mem_addr}, 0);
        expq.delete();
        last_hp = '0;
        repeat (2) @(negedge clk);
        check(mem_rd_en == 1'b0, "no_strobe_in_reset", mem_rd_en, 0);
        reset = 1'b0;
        push_exp(10'd5);
        wait_done();

        for (int it = 0; it < 30; it++) begin
            do a = 10'($urandom_range(8, 1023)); while (a == beat_addr);
            ab = ($urandom_range(0, 3) == 0);
            do m = 10'($urandom_range(8, 1023)); while (m == beat_addr || m == a);
            issue(a, ab, m, int'($urandom_range(1, 3)));
            wait_done();
            repeat ($urandom_range(0, 4)) @(negedge clk);
        end
        repeat (40) @(negedge clk);
        check(expq.size() == 0, "final_queue_empty", expq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
